// File: rtl/elevator_pkg.sv
// Shared encodings and tracker state type for the hall-call return path.
package elevator_pkg;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  localparam int NUM_FLOORS_DEF = 11;
  localparam int NUM_LIFTS_DEF  = 4;

  typedef enum logic [1:0] {IDLE, MOVING, DWELL, CLEAR} clr_state_t;

  // 2'b11 is an invalid encoding and is treated as stopped.
  function automatic logic motor_moving(input logic [1:0] m);
    return (m == MOTOR_UP) || (m == MOTOR_DOWN);
  endfunction

endpackage

// File: rtl/lift_dwell_tracker.sv
// Per-lift tracker: follows one car, holds the door dwell, then requests a clear for its floor.
module lift_dwell_tracker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int FLOOR_W      = 4,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLOOR_W-1:0]    floor_i,
  input  logic [1:0]            motor_i,
  input  logic [NUM_FLOORS-1:0] up_call_i,
  input  logic [NUM_FLOORS-1:0] dn_call_i,
  input  logic                  gnt_i,
  output logic                  req_o,
  output logic [FLOOR_W-1:0]    req_floor_o,
  output logic                  req_up_o,
  output logic                  door_open_o,
  output logic                  err_o
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);

  clr_state_t         state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_up_q, last_up_d;

  logic moving, floor_ok, here_call, up_pend, dn_pend;

  assign moving    = motor_moving(motor_i);
  assign floor_ok  = {1'b0, floor_i} < (FLOOR_W+1)'(NUM_FLOORS);
  assign here_call = floor_ok && (up_call_i[floor_i] || dn_call_i[floor_i]);
  assign up_pend   = up_call_i[floor_q];
  assign dn_pend   = dn_call_i[floor_q];

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    cnt_d     = cnt_q;
    last_up_d = last_up_q;
    req_o     = 1'b0;
    req_up_o  = 1'b0;
    err_o     = 1'b0;
    if (moving && state_q != CLEAR) last_up_d = (motor_i == MOTOR_UP);
    case (state_q)
      IDLE: begin
        if (moving) state_d = MOVING;
        else if (here_call) begin
          state_d = DWELL;
          floor_d = floor_i;
          cnt_d   = CNT_LOAD;
        end
      end
      MOVING: begin
        if (!moving) begin
          if (floor_ok) begin
            state_d = DWELL;
            floor_d = floor_i;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
            err_o   = 1'b1;
          end
        end
      end
      DWELL: begin
        if (moving) state_d = MOVING;
        else if (cnt_q == '0) state_d = CLEAR;
        else cnt_d = cnt_q - 1'b1;
      end
      CLEAR: begin
        // Prefer the direction of travel; fall back to whichever call is still pending.
        if (!(up_pend || dn_pend)) state_d = IDLE;
        else begin
          req_o    = 1'b1;
          req_up_o = last_up_q ? up_pend : !dn_pend;
          if (gnt_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      cnt_q     <= '0;
      last_up_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      cnt_q     <= cnt_d;
      last_up_q <= last_up_d;
    end
  end

  assign req_floor_o = floor_q;
  assign door_open_o = (state_q == DWELL);

endmodule

// File: rtl/hall_call_clearer.sv
// Lift-to-floor responder: per-lift dwell trackers, fixed-priority per-floor clear arbiter.
module hall_call_clearer
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int NUM_LIFTS    = NUM_LIFTS_DEF,
  parameter int FLOOR_W      = 4,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LIFTS*FLOOR_W-1:0]   lift_floor,
  input  logic [2*NUM_LIFTS-1:0]         motor_signal,
  input  logic [NUM_FLOORS-1:0]          U,
  input  logic [NUM_FLOORS-1:0]          D,
  output logic [NUM_FLOORS-1:0]          offFloorReq,
  output logic [NUM_FLOORS-1:0]          offUPorDOWN,
  output logic [NUM_LIFTS-1:0]           door_open,
  output logic                           floor_err
);

  logic [NUM_LIFTS-1:0]              req, req_up, gnt, err;
  logic [NUM_LIFTS-1:0][FLOOR_W-1:0] req_floor;
  logic [NUM_FLOORS-1:0]             off_req_d, off_req_q, off_up_d, off_up_q;
  logic                              floor_err_q;

  for (genvar l = 0; l < NUM_LIFTS; l++) begin : g_lift
    lift_dwell_tracker #(
      .NUM_FLOORS  (NUM_FLOORS),
      .FLOOR_W     (FLOOR_W),
      .DWELL_CYCLES(DWELL_CYCLES)
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .floor_i    (lift_floor[l*FLOOR_W +: FLOOR_W]),
      .motor_i    (motor_signal[2*l +: 2]),
      .up_call_i  (U),
      .dn_call_i  (D),
      .gnt_i      (gnt[l]),
      .req_o      (req[l]),
      .req_floor_o(req_floor[l]),
      .req_up_o   (req_up[l]),
      .door_open_o(door_open[l]),
      .err_o      (err[l])
    );
  end

  // One grant per floor, lowest lift index first; losers hold their request.
  always_comb begin
    off_req_d = '0;
    off_up_d  = '0;
    gnt       = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      for (int l = 0; l < NUM_LIFTS; l++) begin
        if (!off_req_d[f] && req[l] && req_floor[l] == FLOOR_W'(f)) begin
          off_req_d[f] = 1'b1;
          off_up_d[f]  = req_up[l];
          gnt[l]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      off_req_q   <= '0;
      off_up_q    <= '0;
      floor_err_q <= 1'b0;
    end else begin
      off_req_q   <= off_req_d;
      off_up_q    <= off_up_d;
      floor_err_q <= floor_err_q | (|err);
    end
  end

  assign offFloorReq = off_req_q;
  assign offUPorDOWN = off_up_q;
  assign floor_err   = floor_err_q;

endmodule

// File: tb/tb_hall_call_clearer.sv
// Directed bench with a pulse scoreboard and a call-latch model that drops calls on clear.
module tb_hall_call_clearer;

  localparam int NF = 11;
  localparam int NL = 4;
  localparam int FW = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NL*FW-1:0]  lift_floor;
  logic [2*NL-1:0]   motor_signal;
  logic [NF-1:0]     U, D;
  logic [NF-1:0]     offFloorReq, offUPorDOWN;
  logic [NL-1:0]     door_open;
  logic              floor_err;

  hall_call_clearer #(.NUM_FLOORS(NF), .NUM_LIFTS(NL), .FLOOR_W(FW), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .lift_floor(lift_floor), .motor_signal(motor_signal),
    .U(U), .D(D), .offFloorReq(offFloorReq), .offUPorDOWN(offUPorDOWN),
    .door_open(door_open), .floor_err(floor_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int fl; logic up; } exp_t;
  exp_t sbq[$];
  int   cyc, ncmp, nfail;

  task automatic set_lift(input int l, input int fl, input logic [1:0] m);
    logic [31:0] v;
    v = fl;
    lift_floor[l*FW +: FW] = v[FW-1:0];
    motor_signal[2*l +: 2] = m;
  endtask

  task automatic expect_pulse(input int c, input int fl, input logic up);
    exp_t e;
    e.cyc = c; e.fl = fl; e.up = up;
    sbq.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Advance one edge, sample, score pulses, then clear the latched call the pulse answered.
  task automatic tick();
    int idx;
    @(posedge clk);
    cyc++;
    #1;
    chk("dir_without_req", 32'(offUPorDOWN & ~offFloorReq), 32'd0);
    for (int f = 0; f < NF; f++) begin
      if (offFloorReq[f]) begin
        idx = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (idx < 0 && sbq[i].fl == f) idx = i;
        chk($sformatf("pulse_expected_f%0d", f), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          chk($sformatf("pulse_cycle_f%0d", f), 32'(cyc), 32'(sbq[idx].cyc));
          chk($sformatf("pulse_dir_f%0d", f), 32'(offUPorDOWN[f]), 32'(sbq[idx].up));
          sbq.delete(idx);
        end
        if (offUPorDOWN[f]) U[f] = 1'b0;
        else D[f] = 1'b0;
      end
    end
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc < cyc) begin
        chk($sformatf("pulse_missing_f%0d", sbq[i].fl), 32'(sbq[i].cyc), 32'(cyc));
        sbq.delete(i);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) tick();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    int e, dcnt;
    cyc = 0; ncmp = 0; nfail = 0;
    rst = 1'b1; U = '0; D = '0;
    lift_floor = '0; motor_signal = '0;
    set_lift(0, 1, 2'b00); set_lift(1, 9, 2'b00);
    set_lift(2, 10, 2'b00); set_lift(3, 2, 2'b00);
    tick(); tick();
    chk("rst_offFloorReq", 32'(offFloorReq), 32'd0);
    chk("rst_offUPorDOWN", 32'(offUPorDOWN), 32'd0);
    chk("rst_door_open", 32'(door_open), 32'd0);
    chk("rst_floor_err", 32'(floor_err), 32'd0);
    rst = 1'b0;
    tick();

    // Stop with up call: lift0 rises to floor 3 and stops.
    set_lift(0, 3, 2'b01); tick();
    U[3] = 1'b1; set_lift(0, 3, 2'b00); tick();
    e = cyc;
    expect_pulse(e + DW + 1, 3, 1'b1);
    chk("stop_door_open_first", 32'(door_open[0]), 32'd1);
    dcnt = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (door_open[0]) dcnt++;
    end
    chk("stop_dwell_length", 32'(dcnt), 32'(DW));
    drain();

    // Direction preference: lift1 descending to floor 5 with both calls.
    set_lift(1, 9, 2'b10); tick();
    U[5] = 1'b1; D[5] = 1'b1; set_lift(1, 5, 2'b00); tick();
    e = cyc;
    expect_pulse(e + DW + 1, 5, 1'b0);
    expect_pulse(e + 2*DW + 3, 5, 1'b1);
    drain();

    // Collision at floor 7: lift0 wins the first cycle, lift2 clears the other call next.
    set_lift(0, 3, 2'b01); set_lift(2, 10, 2'b01); tick();
    U[7] = 1'b1; D[7] = 1'b1;
    set_lift(0, 7, 2'b00); set_lift(2, 7, 2'b00); tick();
    e = cyc;
    expect_pulse(e + DW + 1, 7, 1'b1);
    expect_pulse(e + DW + 2, 7, 1'b0);
    drain();
    repeat (12) tick();

    // Abort: lift3 restarts at dwell count 4.
    set_lift(3, 2, 2'b01); tick();
    U[4] = 1'b1; set_lift(3, 4, 2'b00); tick();
    repeat (3) tick();
    chk("abort_door_before", 32'(door_open[3]), 32'd1);
    set_lift(3, 4, 2'b01); tick();
    chk("abort_door_after", 32'(door_open[3]), 32'd0);
    repeat (15) tick();
    chk("abort_call_kept", 32'(U[4]), 32'd1);
    U[4] = 1'b0;

    // Idle call: lift3 parked at floor 0, then U[0] rises.
    set_lift(3, 0, 2'b00);
    repeat (12) tick();
    chk("idle_door_closed", 32'(door_open[3]), 32'd0);
    U[0] = 1'b1; tick();
    e = cyc;
    chk("idle_door_open", 32'(door_open[3]), 32'd1);
    expect_pulse(e + DW + 1, 0, 1'b1);
    drain();

    // Stop at an out-of-range floor.
    chk("err_before", 32'(floor_err), 32'd0);
    set_lift(2, 7, 2'b01); tick();
    set_lift(2, 12, 2'b00); tick();
    chk("err_set", 32'(floor_err), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(floor_err), 32'd1);

    // Reset mid-dwell.
    set_lift(1, 5, 2'b01); tick();
    D[6] = 1'b1; set_lift(1, 6, 2'b00); tick();
    repeat (2) tick();
    chk("rst2_door_before", 32'(door_open[1]), 32'd1);
    rst = 1'b1; D[6] = 1'b0; tick();
    chk("rst2_door_open", 32'(door_open), 32'd0);
    chk("rst2_floor_err", 32'(floor_err), 32'd0);
    chk("rst2_offFloorReq", 32'(offFloorReq), 32'd0);
    rst = 1'b0;
    repeat (12) tick();
    chk("rst2_no_pending", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
